alu_seq: RTL

Parametrised, multi-cycle successor to the datapath ALU. It performs W-bit arithmetic, logic, shift, popcount, compare and multiply operations behind a start/done handshake, and holds the z/c/n/v flags in a register that persists between operations. Shifts, popcount and multiply run iteratively, one step per cycle. It sits between the accumulator/register-file read ports and the writeback/branch logic.

---
 rtl/alu_seq.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// Multi-cycle W-bit ALU with start/done handshake and a persistent z/c/n/v flag register.
// Shifts, popcount and multiply iterate one step per cycle; everything else completes on the accept edge.
module alu_seq #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         flush,
  input  logic         optype,
  input  logic [3:0]   op,
  input  logic [W-1:0] acc_in,
  input  logic [W-1:0] reg_in,
  output logic         ready,
  output logic         done,
  output logic [W-1:0] result,
  output logic         z,
  output logic         c,
  output logic         n,
  output logic         v
);

  localparam int CW = $clog2(W + 1);
  localparam logic [W-1:0] L_W = W'(W);

  localparam logic [3:0] OP_ADD = 4'b0010, OP_SUB = 4'b0011, OP_SHL = 4'b0100,
                         OP_SHR = 4'b0101, OP_AND = 4'b0110, OP_OR  = 4'b0111,
                         OP_XOR = 4'b1000, OP_POP = 4'b1001, OP_CMP = 4'b1010,
                         OP_ADC = 4'b1011, OP_MUL = 4'b1100;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t          r_state, w_state_nxt;
  logic [3:0]      r_op;
  logic [CW-1:0]   r_cnt;
  logic [2*W-1:0]  r_a, r_acc;
  logic [W-1:0]    r_b;

  logic            w_busy, w_accept, w_multi, w_last, w_write;
  logic [CW-1:0]   w_s, w_cnt_load;
  logic [3:0]      w_cur_op;
  logic [2*W-1:0]  w_src_a, w_src_acc, w_stp_a, w_stp_acc;
  logic [W-1:0]    w_src_b, w_stp_b, w_res;
  logic            w_stp_cout, w_fz, w_fc, w_fn, w_fv, w_std;
  logic [W:0]      w_sum, w_diff;

  assign ready  = (r_state != S_BUSY);
  assign done   = (r_state == S_DONE);
  assign w_busy = (r_state == S_BUSY);

  always_comb begin
    w_s        = (reg_in >= L_W) ? CW'(W) : reg_in[CW-1:0];
    w_accept   = start && ready && !flush;
    w_multi    = !optype && ((((op == OP_SHL) || (op == OP_SHR)) && (w_s > CW'(1))) ||
                             (op == OP_POP) || (op == OP_MUL));
    w_cnt_load = ((op == OP_POP) || (op == OP_MUL)) ? CW'(W - 1) : (w_s - CW'(1));
    w_last     = w_busy && (r_cnt == CW'(1));
    w_write    = !flush && ((w_accept && !w_multi && !optype) || w_last);

    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: w_state_nxt = w_accept ? (w_multi ? S_BUSY : S_DONE) : S_IDLE;
      S_BUSY:         if (r_cnt == CW'(1)) w_state_nxt = S_DONE;
      default:        w_state_nxt = S_IDLE;
    endcase
    if (flush) w_state_nxt = S_IDLE;
  end

  // One iteration step; on the accept edge it runs on the raw operands, afterwards on the working registers
  always_comb begin
    w_cur_op   = w_busy ? r_op : op;
    w_src_a    = w_busy ? r_a : {{W{1'b0}}, acc_in};
    w_src_b    = w_busy ? r_b : reg_in;
    w_src_acc  = w_busy ? r_acc : '0;
    w_stp_a    = w_src_a;
    w_stp_b    = w_src_b >> 1;
    w_stp_acc  = w_src_acc;
    w_stp_cout = 1'b0;
    case (w_cur_op)
      OP_SHL: begin
        w_stp_a    = {{W{1'b0}}, w_src_a[W-2:0], 1'b0};
        w_stp_cout = w_src_a[W-1];
      end
      OP_SHR: begin
        w_stp_a    = {{W{1'b0}}, 1'b0, w_src_a[W-1:1]};
        w_stp_cout = w_src_a[0];
      end
      OP_POP: w_stp_acc = w_src_acc + {{(2*W-1){1'b0}}, w_src_b[0]};
      OP_MUL: begin
        w_stp_acc = w_src_acc + (w_src_b[0] ? w_src_a : '0);
        w_stp_a   = w_src_a << 1;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_sum  = {1'b0, acc_in} + {1'b0, reg_in} + {{W{1'b0}}, (op == OP_ADC) && c};
    w_diff = {1'b0, acc_in} - {1'b0, reg_in};
    w_res  = '0;
    w_fz   = 1'b0;
    w_fc   = 1'b0;
    w_fn   = 1'b0;
    w_fv   = 1'b0;
    w_std  = 1'b1;
    case (w_cur_op)
      OP_ADD, OP_ADC: begin
        w_res = w_sum[W-1:0];
        w_fc  = w_sum[W];
        w_fv  = (acc_in[W-1] == reg_in[W-1]) && (w_sum[W-1] != acc_in[W-1]);
      end
      OP_SUB: begin
        w_res = w_diff[W-1:0];
        w_fc  = w_diff[W];
        w_fv  = (acc_in[W-1] != reg_in[W-1]) && (w_diff[W-1] != acc_in[W-1]);
      end
      OP_SHL, OP_SHR: begin
        if (w_busy || (w_s != '0)) begin
          w_res = w_stp_a[W-1:0];
          w_fc  = w_stp_cout;
        end else begin
          w_res = acc_in;
        end
      end
      OP_AND: w_res = acc_in & reg_in;
      OP_OR:  w_res = acc_in | reg_in;
      OP_XOR: w_res = acc_in ^ reg_in;
      OP_POP: w_res = w_stp_acc[W-1:0];
      OP_MUL: begin
        w_res = w_stp_acc[W-1:0];
        w_fc  = |w_stp_acc[2*W-1:W];
        w_fv  = |w_stp_acc[2*W-1:W];
      end
      OP_CMP: begin
        w_std = 1'b0;
        w_fz  = (acc_in == reg_in);
        w_fn  = (acc_in < reg_in);
      end
      default: w_std = 1'b0;
    endcase
    if (w_std) begin
      w_fz = (w_res == '0);
      w_fn = w_res[W-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_op  <= op;
        r_cnt <= w_cnt_load;
      end else if (w_busy) begin
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
      z      <= 1'b0;
      c      <= 1'b0;
      n      <= 1'b0;
      v      <= 1'b0;
    end else if (w_write) begin
      result <= w_res;
      z      <= w_fz;
      c      <= w_fc;
      n      <= w_fn;
      v      <= w_fv;
    end
  end

  always_ff @(posedge clk) begin
    if ((w_accept && w_multi) || w_busy) begin
      r_a   <= w_stp_a;
      r_b   <= w_stp_b;
      r_acc <= w_stp_acc;
    end
  end

endmodule
